// File: rtl/anim_sequencer.sv
// Per-frame sprite controller: cel selection, bounced motion and shadowed host config.
// Every output register only loads on frame_start, so the datapath sees stable values all frame.
module anim_sequencer #(
   parameter int H_PIXELS = 640,
   parameter int V_PIXELS = 480,
   parameter int SPRITE_W = 272,
   parameter int SPRITE_H = 176,
   parameter int NUM_CELS = 2,
   parameter int STEP_X   = 2,
   parameter int STEP_Y   = 1,
   localparam int CW      = (NUM_CELS > 1) ? $clog2(NUM_CELS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_start,
   input  logic          run,
   input  logic          step_req,
   output logic          step_ack,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [1:0]    cfg_addr,
   input  logic [9:0]    cfg_data,
   output logic [CW-1:0] cel_index,
   output logic [9:0]    sprite_left,
   output logic [9:0]    sprite_top,
   output logic          dir_x,
   output logic          dir_y
);
   localparam logic [10:0] MAX_X  = 11'(H_PIXELS - SPRITE_W);
   localparam logic [10:0] MAX_Y  = 11'(V_PIXELS - SPRITE_H);
   localparam logic [10:0] STEP_X11 = 11'(STEP_X);
   localparam logic [10:0] STEP_Y11 = 11'(STEP_Y);

   typedef enum logic [1:0] {PAUSED, RUNNING, STEPPING} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cel_q, cel_d;
   logic [9:0]      left_q, left_d, top_q, top_d;
   logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic            step_ack_q, step_ack_d;
   logic [5:0]      period_q, period_d, pcnt_q, pcnt_d;
   logic [3:0][9:0] shd_q, shd_d;
   logic [3:0]      pend_q, pend_d;
   logic            tick;
   logic [10:0]     mv_x, mv_y;

   // Returns {new_dir, new_pos}; 11-bit arithmetic so pos+step never wraps.
   function automatic logic [10:0] move(input logic [9:0] pos, input logic dir,
                                        input logic [10:0] step, input logic [10:0] lim);
      logic [10:0] nx;
      nx = {1'b0, pos} + step;
      if (dir) begin
         if (nx >= lim) move = {1'b0, lim[9:0]};
         else           move = {1'b1, nx[9:0]};
      end else if ({1'b0, pos} <= step) begin
         move = {1'b1, 10'd0};
      end else begin
         move = {1'b0, pos - step[9:0]};
      end
   endfunction

   function automatic logic [9:0] clamp(input logic [9:0] v, input logic [10:0] lim);
      clamp = ({1'b0, v} > lim) ? lim[9:0] : v;
   endfunction

   assign cfg_ready = !frame_start;
   assign tick      = frame_start && (state_q != PAUSED);

   always_comb begin
      state_d    = state_q;
      cel_d      = cel_q;
      left_d     = left_q;
      top_d      = top_q;
      dir_x_d    = dir_x_q;
      dir_y_d    = dir_y_q;
      step_ack_d = 1'b0;
      period_d   = period_q;
      pcnt_d     = pcnt_q;
      shd_d      = shd_q;
      pend_d     = pend_q;
      mv_x       = '0;
      mv_y       = '0;

      case (state_q)
         PAUSED:   if (run) state_d = RUNNING;
                   else if (step_req) state_d = STEPPING;
         RUNNING:  if (!run) state_d = PAUSED;
         STEPPING: if (run) state_d = RUNNING;
                   else if (frame_start) begin
                      state_d    = PAUSED;
                      step_ack_d = 1'b1;
                   end
         default:  state_d = PAUSED;
      endcase

      // cfg_ready excludes frame_start, so a write never races the apply below.
      if (cfg_valid && cfg_ready) begin
         shd_d[cfg_addr]  = cfg_data;
         pend_d[cfg_addr] = 1'b1;
      end

      if (frame_start) begin
         pend_d = '0;
         if (pend_q[3]) begin
            dir_x_d = shd_q[3][0];
            dir_y_d = shd_q[3][1];
         end
         if (pend_q[2]) begin
            period_d = (shd_q[2][5:0] == 6'd0) ? 6'd1 : shd_q[2][5:0];
            pcnt_d   = '0;
         end else if (tick) begin
            if (pcnt_q == period_q - 6'd1) begin
               pcnt_d = '0;
               cel_d  = (cel_q == CW'(NUM_CELS - 1)) ? '0 : cel_q + CW'(1);
            end else begin
               pcnt_d = pcnt_q + 6'd1;
            end
         end
         mv_x = move(left_q, dir_x_d, STEP_X11, MAX_X);
         mv_y = move(top_q, dir_y_d, STEP_Y11, MAX_Y);
         if (pend_q[0]) left_d = clamp(shd_q[0], MAX_X);
         else if (tick) {dir_x_d, left_d} = mv_x;
         if (pend_q[1]) top_d = clamp(shd_q[1], MAX_Y);
         else if (tick) {dir_y_d, top_d} = mv_y;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= PAUSED;
         cel_q      <= '0;
         left_q     <= '0;
         top_q      <= '0;
         dir_x_q    <= 1'b1;
         dir_y_q    <= 1'b1;
         step_ack_q <= 1'b0;
         period_q   <= 6'd16;
         pcnt_q     <= '0;
         shd_q      <= '0;
         pend_q     <= '0;
      end else begin
         state_q    <= state_d;
         cel_q      <= cel_d;
         left_q     <= left_d;
         top_q      <= top_d;
         dir_x_q    <= dir_x_d;
         dir_y_q    <= dir_y_d;
         step_ack_q <= step_ack_d;
         period_q   <= period_d;
         pcnt_q     <= pcnt_d;
         shd_q      <= shd_d;
         pend_q     <= pend_d;
      end
   end

   assign step_ack    = step_ack_q;
   assign cel_index   = cel_q;
   assign sprite_left = left_q;
   assign sprite_top  = top_q;
   assign dir_x       = dir_x_q;
   assign dir_y       = dir_y_q;
endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer: motion, bounce, pause/step, config timing, reset.
module tb_anim_sequencer;
   logic       clk = 1'b0;
   logic       rst_n, frame_start, run, step_req, cfg_valid;
   logic [1:0] cfg_addr;
   logic [9:0] cfg_data;
   logic       step_ack, cfg_ready, dir_x, dir_y;
   logic [0:0] cel_index;
   logic [9:0] sprite_left, sprite_top;
   int checks = 0;
   int failures = 0;

   anim_sequencer dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .run(run),
      .step_req(step_req), .step_ack(step_ack), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cel_index(cel_index), .sprite_left(sprite_left), .sprite_top(sprite_top),
      .dir_x(dir_x), .dir_y(dir_y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic frame();
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [9:0] d);
      @(negedge clk); cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
      @(negedge clk); cfg_valid = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_cel"}, 32'(cel_index), 0);
      chk({tag, "_left"}, 32'(sprite_left), 0);
      chk({tag, "_top"}, 32'(sprite_top), 0);
      chk({tag, "_dirx"}, 32'(dir_x), 1);
      chk({tag, "_diry"}, 32'(dir_y), 1);
      chk({tag, "_ack"}, 32'(step_ack), 0);
   endtask

   initial begin
      rst_n = 1'b0; frame_start = 1'b0; run = 1'b0; step_req = 1'b0;
      cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      chk("reset_ready", 32'(cfg_ready), 1);

      // free run: left +2, top +1 per tick, cel toggles after 16 ticks
      rst_n = 1'b1; run = 1'b1;
      frame();
      chk("run1_left", 32'(sprite_left), 2);
      chk("run1_top", 32'(sprite_top), 1);
      frame();
      chk("run2_left", 32'(sprite_left), 4);
      repeat (13) frame();
      chk("run15_cel", 32'(cel_index), 0);
      chk("run15_left", 32'(sprite_left), 30);
      frame();
      chk("run16_cel", 32'(cel_index), 1);
      chk("run16_left", 32'(sprite_left), 32);
      chk("run16_top", 32'(sprite_top), 16);
      repeat (4) @(negedge clk);
      chk("idle_left", 32'(sprite_left), 32);

      // bounce at right edge
      cfg_write(2'd0, 10'd367);
      cfg_write(2'd3, 10'd3);
      frame();
      chk("bnc_apply_left", 32'(sprite_left), 367);
      chk("bnc_apply_top", 32'(sprite_top), 17);
      frame();
      chk("bnc_edge_left", 32'(sprite_left), 368);
      chk("bnc_edge_dirx", 32'(dir_x), 0);
      frame();
      chk("bnc_back_left", 32'(sprite_left), 366);

      // paused: frames change nothing
      run = 1'b0;
      repeat (5) frame();
      chk("pause_left", 32'(sprite_left), 366);
      chk("pause_top", 32'(sprite_top), 19);
      chk("pause_cel", 32'(cel_index), 1);
      chk("pause_ack", 32'(step_ack), 0);

      // single step
      @(negedge clk); step_req = 1'b1;
      @(negedge clk); step_req = 1'b0;
      frame();
      chk("step_left", 32'(sprite_left), 364);
      chk("step_top", 32'(sprite_top), 20);
      chk("step_ack", 32'(step_ack), 1);
      @(negedge clk);
      chk("step_ack_drop", 32'(step_ack), 0);
      frame();
      chk("step_done_left", 32'(sprite_left), 364);
      chk("step_done_ack", 32'(step_ack), 0);

      // write during frame_start is stalled
      @(negedge clk);
      frame_start = 1'b1; cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 10'd5;
      #1 chk("stall_ready", 32'(cfg_ready), 0);
      @(negedge clk); frame_start = 1'b0; cfg_valid = 1'b0;
      frame();
      chk("stall_left", 32'(sprite_left), 364);

      // clamp, applied while paused
      cfg_write(2'd0, 10'd1000);
      frame();
      chk("clamp_left", 32'(sprite_left), 368);

      // period 0 behaves as 1: cel toggles every tick
      cfg_write(2'd2, 10'd0);
      frame();
      chk("per_apply_cel", 32'(cel_index), 1);
      run = 1'b1;
      frame();
      chk("per_tick1_cel", 32'(cel_index), 0);
      chk("per_tick1_left", 32'(sprite_left), 366);
      frame();
      chk("per_tick2_cel", 32'(cel_index), 1);

      // reset while stepping with a pending write
      run = 1'b0;
      @(negedge clk); step_req = 1'b1;
      @(negedge clk); step_req = 1'b0;
      cfg_write(2'd0, 10'd100);
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("midrst");
      rst_n = 1'b1;
      frame();
      chk_reset("postrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
